// File: rtl/conv_sequencer.sv
// Sequential N-tap discrete convolver: loads x/h over a valid/ready stream, runs one
// shared multiply-accumulate per clock over all N*N index pairs, then drains 2N-1 results.
module conv_sequencer #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_x,
    input  logic [W-1:0]                 in_h,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(2*N-1)-1:0]     out_idx,
    output logic                         out_last,
    output logic                         busy
);

    localparam int R     = 2 * N - 1;
    localparam int IDX_W = $clog2(R);
    localparam int CW    = $clog2(N);

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    load_cnt_reg;
    logic [CW-1:0]    i_reg, j_reg;
    logic [W-1:0]     x_reg   [N];
    logic [W-1:0]     h_reg   [N];
    logic [W-1:0]     acc_reg [R];

    logic             in_ready_reg, out_valid_reg, out_last_reg, busy_reg;
    logic [W-1:0]     data_reg, data_next;
    logic [IDX_W-1:0] idx_reg, idx_next, idx_plus;

    logic             in_accept, out_accept;
    logic             load_done, comp_done, drain_done, j_wrap;
    logic [IDX_W-1:0] addr;
    logic [W-1:0]     x_sel, h_sel, prod_low, acc_sum;

    // in_ready is only ever high in LOAD, so it alone gates input acceptance
    assign in_accept  = in_valid && in_ready_reg;
    assign out_accept = out_valid_reg && out_ready;

    assign load_done  = in_accept && (load_cnt_reg == CW'(N - 1));
    assign j_wrap     = (j_reg == CW'(N - 1));
    assign comp_done  = (state_reg == S_COMPUTE) && j_wrap && (i_reg == CW'(N - 1));
    assign drain_done = out_accept && out_last_reg;

    assign addr     = IDX_W'(i_reg) + IDX_W'(j_reg);
    assign x_sel    = x_reg[i_reg];
    assign h_sel    = h_reg[j_reg];
    // Only the low W bits of the product matter: every accumulation wraps modulo 2^W
    assign prod_low = W'(x_sel * h_sel);
    assign acc_sum  = acc_reg[addr] + prod_low;
    assign idx_plus = idx_reg + IDX_W'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LOAD:    if (load_done)  state_next = S_COMPUTE;
            S_COMPUTE: if (comp_done)  state_next = S_DRAIN;
            S_DRAIN:   if (drain_done) state_next = S_LOAD;
            default:                   state_next = S_LOAD;
        endcase
    end

    // out_data is registered, so the value for the next index is selected one edge early;
    // on DRAIN entry acc[0] is forwarded from the adder in case it was the final update.
    always_comb begin
        idx_next  = idx_reg;
        data_next = data_reg;
        if (comp_done) begin
            idx_next  = '0;
            data_next = (addr == '0) ? acc_sum : acc_reg[0];
        end else if ((state_reg == S_DRAIN) && out_accept) begin
            if (drain_done) begin
                idx_next  = '0;
                data_next = '0;
            end else begin
                idx_next  = idx_plus;
                data_next = acc_reg[idx_plus];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_LOAD;
            load_cnt_reg  <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            data_reg      <= '0;
            idx_reg       <= '0;
            for (int k = 0; k < N; k++) begin
                x_reg[k] <= '0;
                h_reg[k] <= '0;
            end
            for (int k = 0; k < R; k++) begin
                acc_reg[k] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == S_LOAD);
            busy_reg      <= (state_next != S_LOAD);
            out_valid_reg <= (state_next == S_DRAIN);
            out_last_reg  <= (state_next == S_DRAIN) && (idx_next == IDX_W'(R - 1));
            data_reg      <= data_next;
            idx_reg       <= idx_next;

            if (in_accept) begin
                x_reg[load_cnt_reg] <= in_x;
                h_reg[load_cnt_reg] <= in_h;
                load_cnt_reg        <= load_done ? '0 : load_cnt_reg + CW'(1);
            end

            if (load_done) begin
                for (int k = 0; k < R; k++) begin
                    acc_reg[k] <= '0;
                end
                i_reg <= '0;
                j_reg <= '0;
            end else if (state_reg == S_COMPUTE) begin
                acc_reg[addr] <= acc_sum;
                j_reg         <= j_wrap ? '0 : j_reg + CW'(1);
                if (j_wrap) begin
                    i_reg <= (i_reg == CW'(N - 1)) ? '0 : i_reg + CW'(1);
                end
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = data_reg;
    assign out_idx   = idx_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: ones, impulse, wrap-around, backpressure,
// mid-compute reset and back-to-back frames against hand-computed results.
module tb_conv_sequencer;

    localparam int N = 8;
    localparam int W = 4;
    localparam int R = 2 * N - 1;

    typedef logic [W-1:0] smp_t [N];
    typedef int           res_t [R];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_h = '0;
    logic         in_ready, out_valid, out_last, busy;
    logic [W-1:0] out_data;
    logic [3:0]   out_idx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    smp_t ones_v  = '{default: 4'd1};
    smp_t fift_v  = '{default: 4'd15};
    smp_t imp_x   = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    smp_t imp_h   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    res_t exp_tri = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1};
    res_t exp_imp = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0};

    conv_sequencer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_h      (in_h),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " in_ready"},  in_ready,  0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_data"},  out_data,  0);
        check({tag, " out_idx"},   out_idx,   0);
        check({tag, " out_last"},  out_last,  0);
        check({tag, " busy"},      busy,      0);
    endtask

    // Starts and ends on a falling edge; one beat per cycle.
    task automatic load_frame(input string name, input smp_t x, input smp_t h);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s in_ready beat%0d", name, k), in_ready, 1);
            in_valid = 1'b1;
            in_x     = x[k];
            in_h     = h[k];
            @(posedge clk);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        accept_cyc = cyc;
        check({name, " busy after load"},     busy,     1);
        check({name, " in_ready after load"}, in_ready, 0);
        $display("%s loaded at cycle %0d", name, accept_cyc);
    endtask

    task automatic wait_results(input string name, input bit toggle);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                if (toggle) begin
                    in_valid = ~in_valid;
                    in_x     = 4'd7;
                    in_h     = 4'd7;
                    check({name, " in_ready during compute"}, in_ready, 0);
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check({name, " latency"}, seen ? cyc - accept_cyc : -1, N * N);
    endtask

    task automatic drain(input string name, input res_t e, input int stall_idx);
        for (int k = 0; k < R; k++) begin
            check($sformatf("%s valid idx%0d", name, k), out_valid, 1);
            check($sformatf("%s idx idx%0d", name, k),   out_idx,   k);
            check($sformatf("%s data idx%0d", name, k),  out_data,  e[k]);
            check($sformatf("%s last idx%0d", name, k),  out_last,  (k == R - 1) ? 1 : 0);
            $display("%s idx %0d data %0d last %0d", name, out_idx, out_data, out_last);
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    in_valid = 1'b1;
                    in_x     = 4'd9;
                    in_h     = 4'd9;
                    @(negedge clk);
                    check($sformatf("%s stall%0d valid", name, s), out_valid, 1);
                    check($sformatf("%s stall%0d idx", name, s),   out_idx,   k);
                    check($sformatf("%s stall%0d data", name, s),  out_data,  e[k]);
                    check($sformatf("%s stall%0d in_ready", name, s), in_ready, 0);
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check({name, " valid after last"},    out_valid, 0);
        check({name, " busy after last"},     busy,      0);
        check({name, " in_ready after last"}, in_ready,  1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after release", in_ready, 1);
        check("busy after release",     busy,     0);

        load_frame("ones", ones_v, ones_v);
        wait_results("ones", 1'b0);
        drain("ones", exp_tri, -1);

        // back-to-back: the next frame starts on the cycle right after out_last
        load_frame("impulse", imp_x, imp_h);
        wait_results("impulse", 1'b0);
        drain("impulse", exp_imp, -1);

        load_frame("wrap", fift_v, fift_v);
        wait_results("wrap", 1'b0);
        drain("wrap", exp_tri, -1);

        load_frame("bp", ones_v, ones_v);
        wait_results("bp", 1'b1);
        drain("bp", exp_tri, 3);

        load_frame("abort", ones_v, ones_v);
        repeat (30) @(negedge clk);
        check("abort busy before reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("midreset");
        @(negedge clk);
        check_idle_zero("midreset held");
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset in_ready after release",  in_ready,  1);
        check("midreset out_valid after release", out_valid, 0);
        check("midreset busy after release",      busy,      0);

        load_frame("clean", imp_x, imp_h);
        wait_results("clean", 1'b0);
        drain("clean", exp_imp, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Sequential controller for the team's 8×8-tap, 4-bit discrete convolution. It accepts the x and h sample sequences over a valid/ready stream and sequences one shared multiply-accumulate step per clock across all N×N index pairs. It then drains the 2N−1 result words over a valid/ready output stream. Results are bit-exact with the existing combinational convolver, which wraps modulo 2^W on every accumulation; this block is the area-reduced replacement where one product per cycle is acceptable.

## Interface
- N, default 8: sequence length for both x and h; legal range 2..16.
- W, default 4: sample and result width in bits; every result wraps modulo 2^W.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- in_valid  in  1  in_x/in_h beat is valid.
- in_ready  out  1  block accepts a beat; high only in LOAD.
- in_x  in  W  next x sample; beat k supplies x[k].
- in_h  in  W  next h sample; beat k supplies h[k].
- out_valid  out  1  out_data/out_idx hold a valid result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  W  result[out_idx].
- out_idx  out  ceil(log2(2N−1))  result index, 0..2N−2.
- out_last  out  1  high with the beat where out_idx = 2N−2.
- busy  out  1  high in COMPUTE and DRAIN.

## Operation
- Three states: LOAD, COMPUTE, DRAIN. Reset enters LOAD.
- A beat is accepted when in_valid and in_ready are both high on a rising edge.
- LOAD:
  - Accepted beat k writes x_reg[k] and h_reg[k], then increments the load counter.
  - When beat N−1 is accepted, the block clears all 2N−1 accumulators and goes to COMPUTE with i=j=0.
- COMPUTE:
  - Each cycle performs acc[i+j] ← (acc[i+j] + x_reg[i]·h_reg[j]) mod 2^W.
  - The product is W×W→2W bits; only the low W bits are added.
  - Index order: j is inner, i is outer; j wraps N−1→0 and i increments on that wrap.
  - The cycle with i=j=N−1 is the last one; the block then goes to DRAIN with out_idx=0.
- DRAIN:
  - out_valid is high. out_data = acc[out_idx].
  - An accepted output beat increments out_idx.
  - The beat with out_last high returns the block to LOAD.
- Beat handling outside LOAD:
  - in_valid outside LOAD is ignored; nothing is consumed and no register changes.
  - out_ready outside DRAIN is ignored.
- No partial load abort. Only rst_n aborts.

## Timing
- Reset values: in_ready=0 while rst_n is low, then 1 from the first edge after release.
- All other outputs reset to 0: out_valid, out_data, out_idx, out_last, busy.
- Counters and accumulators reset to 0. x_reg/h_reg reset to 0.
- Throughput in LOAD: one beat per cycle when in_valid stays high; gaps in in_valid stall the load indefinitely.
- Latency: the last input beat is accepted at edge t.
  - COMPUTE occupies the N² cycles after edge t; busy=1 from edge t.
  - out_valid first goes high after edge t+N² (t+64 at N=8).
- Output handshake:
  - out_data, out_idx and out_last are held stable while out_valid=1 and out_ready=0.
  - With out_ready held high, one result drains per cycle; DRAIN lasts 2N−1 cycles minimum.
- On the out_last acceptance edge: out_valid→0, busy→0, in_ready→1. The next frame may be accepted starting the following edge.
- The outputs are registered.
  - out_data must show the accumulator value including the final COMPUTE update.
  - The implementation must not read stale data for idx 2N−2.
- Reset mid-operation: assertion in any state clears all state immediately and asynchronously. No partial output is emitted after release.

## Test plan
- Uniform ones: x=h=all 1, out_ready=1.
  - Required: out_data for idx 0..14 = 1,2,3,4,5,6,7,8,7,6,5,4,3,2,1.
  - out_last only on idx 14.
  - out_valid first high 64 cycles after the last input accept.
- Impulse: x=[1,0,0,0,0,0,0,0], h=[1,2,3,4,5,6,7,8].
  - Required: outputs 1,2,3,4,5,6,7,8 followed by seven 0s.
- Wrap-around: x=h=all 15.
  - Each product is 225, which wraps to 1 mod 16.
  - Required: the same 1..8..1 sequence as the uniform-ones case; an untruncated implementation fails.
- Backpressure and ignored beats:
  - Stimulus: uniform-ones frame; toggle in_valid during COMPUTE; hold out_ready=0 for 5 cycles at idx 3, then 1.
  - Required: idx 3 holds value 4 stable for all 5 cycles; no input consumed before DRAIN ends; total frame results unchanged.
- Reset mid-COMPUTE, then a clean frame:
  - Stimulus: assert rst_n=0 at compute cycle 30; release; load the impulse frame.
  - Required: all outputs read 0 during reset; the impulse frame results are exactly as specified, with no carry-over.
- Back-to-back frames: two frames whose first beat is sent on the cycle after out_last.
  - Required: in_ready=1 on that cycle; the second frame's results are independent of the first.
